// File: rtl/tile_pkg.sv
// Shared definitions for the multi-cursor tile controller: direction encoding,
// channel FSM states and the coordinate width helper.
package tile_pkg;

   // Bit positions of each direction inside a cursor's 4-bit request slice
   localparam int DIR_UP    = 0;
   localparam int DIR_DOWN  = 1;
   localparam int DIR_LEFT  = 2;
   localparam int DIR_RIGHT = 3;

   typedef enum logic [1:0] {
      MV_UP    = 2'd0,
      MV_DOWN  = 2'd1,
      MV_LEFT  = 2'd2,
      MV_RIGHT = 2'd3
   } dir_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } ch_state_e;

   // Bits needed to index n tiles (or n counter values); never less than one
   function automatic int tile_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_cursor_ctrl_if.sv
// Request/position bundle between the cursor controller and its client.
interface multi_cursor_ctrl_if
   import tile_pkg::*;
#(
   parameter int NUM_CURSORS = 2,
   parameter int H_TILES     = 10,
   parameter int V_TILES     = 6
);
   localparam int HW = tile_width(H_TILES);
   localparam int VW = tile_width(V_TILES);

   logic [4*NUM_CURSORS-1:0]  dir_req;
   logic [HW*NUM_CURSORS-1:0] pos_h;
   logic [VW*NUM_CURSORS-1:0] pos_v;
   logic [NUM_CURSORS-1:0]    moved;
   logic [NUM_CURSORS-1:0]    blocked;

   modport master (output dir_req, input pos_h, pos_v, moved, blocked);
   modport slave  (input dir_req, output pos_h, pos_v, moved, blocked);

endinterface

// File: rtl/multi_cursor_ctrl_channel.sv
// One cursor's key handling: IDLE/HOLD FSM with auto-repeat counter, direction
// priority and the raw (unchecked) neighbour tile it would move to.
module cursor_channel
   import tile_pkg::*;
#(
   parameter int REPEAT_CYC = 4,
   parameter int HW         = 4,
   parameter int VW         = 3
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    i_dir_req,
   input  logic [HW-1:0] i_pos_h,
   input  logic [VW-1:0] i_pos_v,
   output logic          o_attempt,
   output dir_e          o_dir,
   output logic [HW-1:0] o_tgt_h,
   output logic [VW-1:0] o_tgt_v
);
   localparam int            CW       = tile_width(REPEAT_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(REPEAT_CYC - 1);

   ch_state_e     r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [3:0]    r_req_q;
   logic          w_any;

   assign w_any = |i_dir_req;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_req_q <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_req_q <= i_dir_req;
      end
   end

   // NOTE: every output of this block gets a default first so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_attempt   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = '0;
               o_attempt   = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!w_any) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (i_dir_req != r_req_q || r_cnt == CNT_LAST) begin
               // A new key pattern acts like a fresh press and restarts the repeat period
               w_cnt_nxt = '0;
               o_attempt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_dir   = MV_RIGHT;
      o_tgt_h = i_pos_h;
      o_tgt_v = i_pos_v;
      if (i_dir_req[DIR_UP])        o_dir = MV_UP;
      else if (i_dir_req[DIR_DOWN]) o_dir = MV_DOWN;
      else if (i_dir_req[DIR_LEFT]) o_dir = MV_LEFT;
      unique case (o_dir)
         MV_UP:    o_tgt_v = i_pos_v - VW'(1);
         MV_DOWN:  o_tgt_v = i_pos_v + VW'(1);
         MV_LEFT:  o_tgt_h = i_pos_h - HW'(1);
         MV_RIGHT: o_tgt_h = i_pos_h + HW'(1);
         default:  o_tgt_h = i_pos_h;
      endcase
   end

endmodule

// File: rtl/multi_cursor_ctrl.sv
// Multi-cursor grid controller: per-cursor channels propose moves; this level
// applies edge saturation/wrap, occupancy and same-target arbitration.
module multi_cursor_ctrl
   import tile_pkg::*;
#(
   parameter int NUM_CURSORS = 2,
   parameter int H_TILES     = 10,
   parameter int V_TILES     = 6,
   parameter int REPEAT_CYC  = 2**25,
   parameter int WRAP        = 0
)(
   input  logic                clk,
   input  logic                rst,
   multi_cursor_ctrl_if.slave  bus
);
   localparam int HW = tile_width(H_TILES);
   localparam int VW = tile_width(V_TILES);

   logic [HW-1:0]          r_pos_h [NUM_CURSORS];
   logic [VW-1:0]          r_pos_v [NUM_CURSORS];
   logic [NUM_CURSORS-1:0] r_moved, r_blocked;

   logic [NUM_CURSORS-1:0] w_attempt, w_edge, w_cand_ok, w_occ, w_lost, w_move;
   dir_e                   w_dir   [NUM_CURSORS];
   logic [HW-1:0]          w_raw_h [NUM_CURSORS];
   logic [VW-1:0]          w_raw_v [NUM_CURSORS];
   logic [HW-1:0]          w_tgt_h [NUM_CURSORS];
   logic [VW-1:0]          w_tgt_v [NUM_CURSORS];

   for (genvar g = 0; g < NUM_CURSORS; g++) begin : g_ch
      cursor_channel #(
         .REPEAT_CYC (REPEAT_CYC),
         .HW         (HW),
         .VW         (VW)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .i_dir_req (bus.dir_req[4*g +: 4]),
         .i_pos_h   (r_pos_h[g]),
         .i_pos_v   (r_pos_v[g]),
         .o_attempt (w_attempt[g]),
         .o_dir     (w_dir[g]),
         .o_tgt_h   (w_raw_h[g]),
         .o_tgt_v   (w_raw_v[g])
      );
   end

   always_comb begin
      w_edge    = '0;
      w_cand_ok = '0;
      w_occ     = '0;
      w_lost    = '0;
      w_move    = '0;
      for (int i = 0; i < NUM_CURSORS; i++) begin
         w_tgt_h[i] = w_raw_h[i];
         w_tgt_v[i] = w_raw_v[i];
         unique case (w_dir[i])
            MV_UP:    if (r_pos_v[i] == '0) begin
                         w_edge[i]  = 1'b1;
                         w_tgt_v[i] = VW'(V_TILES - 1);
                      end
            MV_DOWN:  if (r_pos_v[i] == VW'(V_TILES - 1)) begin
                         w_edge[i]  = 1'b1;
                         w_tgt_v[i] = '0;
                      end
            MV_LEFT:  if (r_pos_h[i] == '0) begin
                         w_edge[i]  = 1'b1;
                         w_tgt_h[i] = HW'(H_TILES - 1);
                      end
            MV_RIGHT: if (r_pos_h[i] == HW'(H_TILES - 1)) begin
                         w_edge[i]  = 1'b1;
                         w_tgt_h[i] = '0;
                      end
            default:  w_edge[i] = 1'b0;
         endcase
         w_cand_ok[i] = w_attempt[i] && !(w_edge[i] && WRAP == 0);
      end
      // Occupancy is judged on current positions, so two cursors can never swap or chase
      for (int i = 0; i < NUM_CURSORS; i++) begin
         for (int j = 0; j < NUM_CURSORS; j++) begin
            if (j != i && r_pos_h[j] == w_tgt_h[i] && r_pos_v[j] == w_tgt_v[i])
               w_occ[i] = 1'b1;
            if (j < i && w_cand_ok[j] && w_tgt_h[j] == w_tgt_h[i] && w_tgt_v[j] == w_tgt_v[i])
               w_lost[i] = 1'b1;
         end
         w_move[i] = w_cand_ok[i] && !w_occ[i] && !w_lost[i];
      end
   end

   // NOTE: only the small position/pulse registers are reset; cursor i starts
   // on column i so no two cursors ever share a tile.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CURSORS; i++) begin
            r_pos_h[i] <= HW'(i);
            r_pos_v[i] <= '0;
         end
         r_moved   <= '0;
         r_blocked <= '0;
      end else begin
         for (int i = 0; i < NUM_CURSORS; i++) begin
            if (w_move[i]) begin
               r_pos_h[i] <= w_tgt_h[i];
               r_pos_v[i] <= w_tgt_v[i];
            end
         end
         r_moved   <= w_move;
         r_blocked <= w_attempt & ~w_move;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CURSORS; i++) begin
         bus.pos_h[HW*i +: HW] = r_pos_h[i];
         bus.pos_v[VW*i +: VW] = r_pos_v[i];
      end
   end

   assign bus.moved   = r_moved;
   assign bus.blocked = r_blocked;

endmodule

// File: tb/tb_multi_cursor_ctrl.sv
// Scoreboard bench for multi_cursor_ctrl: a saturating and a wrapping instance,
// directed key presses with hand-computed move/block events.
module tb_multi_cursor_ctrl;
   import tile_pkg::*;

   localparam int N  = 2;
   localparam int H  = 10;
   localparam int V  = 6;
   localparam int RC = 4;

   typedef struct {
      int         cyc;
      logic [1:0] moved;
      logic [1:0] blocked;
      logic [7:0] pos_h;
      logic [5:0] pos_v;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q_sat[$];
   exp_t q_wrap[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multi_cursor_ctrl_if #(.NUM_CURSORS(N), .H_TILES(H), .V_TILES(V)) bus_sat ();
   multi_cursor_ctrl_if #(.NUM_CURSORS(N), .H_TILES(H), .V_TILES(V)) bus_wrap ();

   multi_cursor_ctrl #(
      .NUM_CURSORS(N), .H_TILES(H), .V_TILES(V), .REPEAT_CYC(RC), .WRAP(0)
   ) u_dut_sat (.clk(clk), .rst(rst), .bus(bus_sat));

   multi_cursor_ctrl #(
      .NUM_CURSORS(N), .H_TILES(H), .V_TILES(V), .REPEAT_CYC(RC), .WRAP(1)
   ) u_dut_wrap (.clk(clk), .rst(rst), .bus(bus_wrap));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input bit wrap, input int at, input logic [1:0] mv, input logic [1:0] bl,
                       input logic [7:0] ph, input logic [5:0] pv);
      exp_t e;
      e.cyc = at; e.moved = mv; e.blocked = bl; e.pos_h = ph; e.pos_v = pv;
      if (wrap) q_wrap.push_back(e);
      else      q_sat.push_back(e);
   endtask

   task automatic mon_evt(input bit wrap, input logic [1:0] mv, input logic [1:0] bl,
                          input logic [7:0] ph, input logic [5:0] pv);
      exp_t  e;
      string tag = wrap ? "wrap" : "sat";
      if ((wrap ? q_wrap.size() : q_sat.size()) == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_unexpected_event: got moved=%b blocked=%b pos_h=%h pos_v=%h, expected none (cycle %0d)",
                  tag, mv, bl, ph, pv, cyc);
         return;
      end
      e = wrap ? q_wrap.pop_front() : q_sat.pop_front();
      check($sformatf("%s_evt_cycle", tag), 64'(cyc), 64'(e.cyc));
      check($sformatf("%s_moved", tag), 64'(mv), 64'(e.moved));
      check($sformatf("%s_blocked", tag), 64'(bl), 64'(e.blocked));
      check($sformatf("%s_pos_h", tag), 64'(ph), 64'(e.pos_h));
      check($sformatf("%s_pos_v", tag), 64'(pv), 64'(e.pos_v));
   endtask

   // Monitor: any moved/blocked pulse is an output event to be matched
   always @(negedge clk) begin
      if (!rst) begin
         if ((bus_sat.moved | bus_sat.blocked) != 2'b00)
            mon_evt(1'b0, bus_sat.moved, bus_sat.blocked, bus_sat.pos_h, bus_sat.pos_v);
         if ((bus_wrap.moved | bus_wrap.blocked) != 2'b00)
            mon_evt(1'b1, bus_wrap.moved, bus_wrap.blocked, bus_wrap.pos_h, bus_wrap.pos_v);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Single press on the saturating instance: request for one cycle, then release
   task automatic press_sat(input logic [7:0] req, input logic [1:0] mv, input logic [1:0] bl,
                            input logic [7:0] ph, input logic [5:0] pv);
      push(1'b0, cyc + 1, mv, bl, ph, pv);
      bus_sat.dir_req = req;
      tick(1);
      bus_sat.dir_req = '0;
      tick(1);
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_sat_pos_h"}, 64'(bus_sat.pos_h), 64'h10);
      check({name, "_sat_pos_v"}, 64'(bus_sat.pos_v), 64'h0);
      check({name, "_sat_pulses"}, 64'({bus_sat.moved, bus_sat.blocked}), 64'h0);
      check({name, "_wrap_pos_h"}, 64'(bus_wrap.pos_h), 64'h10);
      check({name, "_wrap_pos_v"}, 64'(bus_wrap.pos_v), 64'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      check_reset_state("reset");
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      check({name, "_sat_queue_left"}, 64'(q_sat.size()), 64'd0);
      check({name, "_wrap_queue_left"}, 64'(q_wrap.size()), 64'd0);
   endtask

   int base;

   initial begin
      bus_sat.dir_req  = '0;
      bus_wrap.dir_req = '0;
      tick(3);
      check_reset_state("por");
      rst = 1'b0;
      tick(4);
      check_reset_state("idle");

      // Cursor1 right held 9 cycles: attempts at press, +4, +8
      base = cyc;
      push(1'b0, base + 1, 2'b10, 2'b00, 8'h20, 6'h00);
      push(1'b0, base + 5, 2'b10, 2'b00, 8'h30, 6'h00);
      push(1'b0, base + 9, 2'b10, 2'b00, 8'h40, 6'h00);
      bus_sat.dir_req = 8'h80;
      tick(9);
      bus_sat.dir_req = '0;
      tick(6);
      drain("repeat");

      // Cursor0 up at the top edge: saturate vs wrap to row 5
      push(1'b0, cyc + 1, 2'b00, 2'b01, 8'h40, 6'h00);
      push(1'b1, cyc + 1, 2'b01, 2'b00, 8'h10, 6'h05);
      bus_sat.dir_req  = 8'h01;
      bus_wrap.dir_req = 8'h01;
      tick(1);
      bus_sat.dir_req  = '0;
      bus_wrap.dir_req = '0;
      tick(3);
      drain("edge");

      // Occupied target, including a cursor that moves away in the same cycle
      do_reset();
      press_sat(8'h08, 2'b00, 2'b01, 8'h10, 6'h00);
      press_sat(8'h88, 2'b10, 2'b01, 8'h20, 6'h00);
      tick(2);
      drain("occupied");

      // Build (2,0)/(4,0) then both aim at (3,0): lower index wins
      press_sat(8'h80, 2'b10, 2'b00, 8'h30, 6'h00);
      press_sat(8'h80, 2'b10, 2'b00, 8'h40, 6'h00);
      press_sat(8'h08, 2'b01, 2'b00, 8'h41, 6'h00);
      press_sat(8'h08, 2'b01, 2'b00, 8'h42, 6'h00);
      press_sat(8'h48, 2'b01, 2'b10, 8'h43, 6'h00);
      tick(2);
      drain("conflict");

      // Priority: up+right from (0,3) goes up only
      do_reset();
      press_sat(8'h02, 2'b01, 2'b00, 8'h10, 6'h01);
      press_sat(8'h02, 2'b01, 2'b00, 8'h10, 6'h02);
      press_sat(8'h02, 2'b01, 2'b00, 8'h10, 6'h03);
      press_sat(8'h09, 2'b01, 2'b00, 8'h10, 6'h02);
      tick(2);
      drain("priority");

      // Reset lands on a repeat cycle; request held through release re-attempts at once
      push(1'b0, cyc + 1, 2'b10, 2'b00, 8'h20, 6'h02);
      bus_sat.dir_req = 8'h80;
      tick(4);
      rst = 1'b1;
      tick(1);
      check_reset_state("mid_hold");
      rst = 1'b0;
      push(1'b0, cyc + 1, 2'b10, 2'b00, 8'h20, 6'h00);
      tick(1);
      bus_sat.dir_req = '0;
      tick(4);
      drain("mid_hold");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
